// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions. This package holds the default operand and tag
// widths, the forwarding-source index map, and the selection encoding that the
// forwarding stages share.
package arm_pipe_pkg;

    // Default data and register-tag widths (R0-R15)
    localparam int ARM_WORD_LENGTH = 32;
    localparam int ARM_TAG_WIDTH   = 4;

    // Forwarding source indices. A lower index is a younger writer.
    localparam int unsigned FWD_SRC_MEM = 0;
    localparam int unsigned FWD_SRC_WB  = 1;

    // Selection encoding: 0 = register file, i+1 = forwarding source i
    localparam int unsigned SEL_REGFILE = 0;

endpackage

// File: rtl/fwd_priority_select.sv
// fwd_priority_select: combinational priority selector for forwarded operands.
// The lowest-indexed (youngest) asserted match wins. With no match, the default
// data passes through.
// Ports:
//   match        in  NUM_SRC              per-source match flags
//   fwd_data     in  NUM_SRC*WORD_LENGTH  packed source data, source i at [i*W +: W]
//   default_data in  WORD_LENGTH          value used when nothing matches
//   sel_next     out SEL_W                0 = default, i+1 = source i
//   value_next   out WORD_LENGTH          selected value
module fwd_priority_select
    import arm_pipe_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int WORD_LENGTH = ARM_WORD_LENGTH,
    localparam int SEL_W      = $clog2(NUM_SRC + 1)
)(
    input  logic [NUM_SRC-1:0]             match,
    input  logic [NUM_SRC*WORD_LENGTH-1:0] fwd_data,
    input  logic [WORD_LENGTH-1:0]         default_data,
    output logic [SEL_W-1:0]               sel_next,
    output logic [WORD_LENGTH-1:0]         value_next
);

    logic found;

    // Scan from the youngest source upward. The first hit sets the found flag,
    // which blocks every older source.
    always_comb begin
        found      = 1'b0;
        sel_next   = SEL_W'(SEL_REGFILE);
        value_next = default_data;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (match[i] && !found) begin
                found      = 1'b1;
                sel_next   = SEL_W'(i + 1);
                value_next = fwd_data[i*WORD_LENGTH +: WORD_LENGTH];
            end
        end
    end

endmodule

// File: rtl/operand_forward_stage.sv
// operand_forward_stage: registered operand-forwarding selector at the ID/EX
// boundary. It compares the operand's source tag against NUM_SRC in-flight writers
// and picks the youngest match, or the register-file value when none match.
// The result is registered, with stall (hold) and flush (bubble).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   stall, flush   hold / squash controls; flush wins over stall
//   in_valid       ID instruction uses this operand
//   src_tag        operand source register
//   id_value       register-file read value
//   fwd_valid      per-source write-back flag
//   fwd_tag        packed destination tags, source i at [i*TAG_WIDTH +: TAG_WIDTH]
//   fwd_data       packed forwarded data, same packing
//   out_value      registered selected operand
//   out_valid      registered operand valid
//   out_sel        registered selection (0 = regfile, i+1 = source i)
//   fwd_hit_count  saturating count of accepted forwarded operands
module operand_forward_stage
    import arm_pipe_pkg::*;
#(
    parameter int WORD_LENGTH = ARM_WORD_LENGTH,
    parameter int NUM_SRC     = 2,
    parameter int TAG_WIDTH   = ARM_TAG_WIDTH,
    parameter int CNT_WIDTH   = 16,
    localparam int SEL_W      = $clog2(NUM_SRC + 1)
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [TAG_WIDTH-1:0]           src_tag,
    input  logic [WORD_LENGTH-1:0]         id_value,
    input  logic [NUM_SRC-1:0]             fwd_valid,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]   fwd_tag,
    input  logic [NUM_SRC*WORD_LENGTH-1:0] fwd_data,
    output logic [WORD_LENGTH-1:0]         out_value,
    output logic                           out_valid,
    output logic [SEL_W-1:0]               out_sel,
    output logic [CNT_WIDTH-1:0]           fwd_hit_count
);

    logic [NUM_SRC-1:0]     match;
    logic [SEL_W-1:0]       sel_next;
    logic [WORD_LENGTH-1:0] value_next;
    logic                   fwd_taken;

    // Gating the matches with in_valid forces selection to the register file
    // for an unused operand. The selected data is then id_value, which is
    // deterministic.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            match[i] = in_valid && fwd_valid[i] &&
                       (fwd_tag[i*TAG_WIDTH +: TAG_WIDTH] == src_tag);
        end
    end

    fwd_priority_select #(
        .NUM_SRC     (NUM_SRC),
        .WORD_LENGTH (WORD_LENGTH)
    ) u_select (
        .match        (match),
        .fwd_data     (fwd_data),
        .default_data (id_value),
        .sel_next     (sel_next),
        .value_next   (value_next)
    );

    assign fwd_taken = in_valid && (sel_next != SEL_W'(SEL_REGFILE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_value     <= '0;
            out_valid     <= 1'b0;
            out_sel       <= '0;
            fwd_hit_count <= '0;
        end else if (flush) begin
            out_value <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
        end else if (!stall) begin
            out_value <= value_next;
            out_valid <= in_valid;
            out_sel   <= sel_next;
            if (fwd_taken && (fwd_hit_count != '1)) begin
                fwd_hit_count <= fwd_hit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_forward_stage.sv
module tb_operand_forward_stage;
    import arm_pipe_pkg::*;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int T  = 4;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           stall, flush, in_valid;
    logic [T-1:0]   src_tag;
    logic [W-1:0]   id_value;
    logic [N-1:0]   fwd_valid;
    logic [N*T-1:0] fwd_tag;
    logic [N*W-1:0] fwd_data;
    logic [W-1:0]   out_value;
    logic           out_valid;
    logic [1:0]     out_sel;
    logic [CW-1:0]  fwd_hit_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  value;
        logic          valid;
        logic [1:0]    sel;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t sb[$];

    // Reference state of the registered outputs
    logic [W-1:0]  m_value;
    logic          m_valid;
    logic [1:0]    m_sel;
    logic [CW-1:0] m_cnt;

    operand_forward_stage #(
        .WORD_LENGTH (W),
        .NUM_SRC     (N),
        .TAG_WIDTH   (T),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .src_tag       (src_tag),
        .id_value      (id_value),
        .fwd_valid     (fwd_valid),
        .fwd_tag       (fwd_tag),
        .fwd_data      (fwd_data),
        .out_value     (out_value),
        .out_valid     (out_valid),
        .out_sel       (out_sel),
        .fwd_hit_count (fwd_hit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus from the falling edge, advance the reference
    // model, and compare the DUT outputs just after the next rising edge.
    task automatic step(input string name, input logic st, input logic fl,
                        input logic iv, input logic [T-1:0] tag,
                        input logic [W-1:0] idv, input logic [N-1:0] fv,
                        input logic [T-1:0] t1, input logic [T-1:0] t0,
                        input logic [W-1:0] d1, input logic [W-1:0] d0);
        exp_t e;
        exp_t got;
        logic [1:0]   s;
        logic [W-1:0] v;
        logic [T-1:0] tg [N];
        logic [W-1:0] dt [N];
        stall    = st;
        flush    = fl;
        in_valid = iv;
        src_tag  = tag;
        id_value = idv;
        fwd_valid = fv;
        fwd_tag  = '0;
        fwd_data = '0;
        fwd_tag[FWD_SRC_MEM*T +: T]  = t0;
        fwd_tag[FWD_SRC_WB*T +: T]   = t1;
        fwd_data[FWD_SRC_MEM*W +: W] = d0;
        fwd_data[FWD_SRC_WB*W +: W]  = d1;
        tg[0] = t0; tg[1] = t1;
        dt[0] = d0; dt[1] = d1;
        // Youngest hit: search from the oldest source down so the last hit wins
        s = 2'd0;
        v = idv;
        if (iv) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (fv[k] && tg[k] == tag) begin
                    s = 2'(k + 1);
                    v = dt[k];
                end
            end
        end
        if (fl) begin
            m_value = '0; m_valid = 1'b0; m_sel = 2'd0;
        end else if (!st) begin
            m_value = v; m_valid = iv; m_sel = s;
            if (s != 2'd0 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
        e.value = m_value; e.valid = m_valid; e.sel = m_sel; e.cnt = m_cnt; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.name, ".value"}, 64'(out_value), 64'(got.value));
        check({got.name, ".valid"}, 64'(out_valid), 64'(got.valid));
        check({got.name, ".sel"},   64'(out_sel),   64'(got.sel));
        check({got.name, ".count"}, 64'(fwd_hit_count), 64'(got.cnt));
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, ".value"}, 64'(out_value), 64'd0);
        check({name, ".valid"}, 64'(out_valid), 64'd0);
        check({name, ".sel"},   64'(out_sel),   64'd0);
        check({name, ".count"}, 64'(fwd_hit_count), 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        src_tag = '0; id_value = '0; fwd_valid = '0; fwd_tag = '0; fwd_data = '0;
        m_value = '0; m_valid = 1'b0; m_sel = 2'd0; m_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        step("release_idle", 0, 0, 0, 4'd0, 32'h0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        step("no_hazard",    0, 0, 1, 4'd3, 32'h11, 2'b00, 4'd3, 4'd3, 32'h55, 32'h66);
        step("prio_both",    0, 0, 1, 4'd5, 32'h1, 2'b11, 4'd5, 4'd5, 32'hBBBB, 32'hAAAA);
        step("prio_wb_only", 0, 0, 1, 4'd5, 32'h1, 2'b10, 4'd5, 4'd5, 32'hBBBB, 32'hAAAA);
        step("tag_mismatch", 0, 0, 1, 4'd7, 32'h77, 2'b11, 4'd6, 4'd8, 32'hB1, 32'hA1);
        step("fv_gate",      0, 0, 1, 4'd9, 32'h99, 2'b01, 4'd2, 4'd9, 32'hB2, 32'hA2);
        step("unused_op",    0, 0, 0, 4'd4, 32'h44, 2'b11, 4'd4, 4'd4, 32'hB3, 32'hA3);
        step("tag_r15",      0, 0, 1, 4'd15, 32'h15, 2'b10, 4'd15, 4'd15, 32'hF15, 32'hE15);

        step("stall_0", 1, 0, 1, 4'd1, 32'h1234, 2'b01, 4'd0, 4'd1, 32'hC0, 32'hC1);
        step("stall_1", 1, 0, 0, 4'd2, 32'h2345, 2'b11, 4'd2, 4'd2, 32'hC2, 32'hC3);
        step("stall_2", 1, 0, 1, 4'd3, 32'h3456, 2'b10, 4'd3, 4'd0, 32'hC4, 32'hC5);
        step("unstall", 0, 0, 1, 4'd3, 32'h3456, 2'b10, 4'd3, 4'd0, 32'hC4, 32'hC5);

        step("flush_stall", 1, 1, 1, 4'd6, 32'h6, 2'b11, 4'd6, 4'd6, 32'hD6, 32'hE6);
        step("after_flush", 0, 0, 1, 4'd6, 32'h6, 2'b01, 4'd0, 4'd6, 32'hD6, 32'hE6);

        // Asynchronous reset in the middle of the low phase
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        m_value = '0; m_valid = 1'b0; m_sel = 2'd0; m_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        step("rst_release_stall", 1, 0, 1, 4'd2, 32'h22, 2'b01, 4'd0, 4'd2, 32'h0, 32'h2222);
        step("rst_release_idle",  0, 0, 0, 4'd2, 32'h22, 2'b01, 4'd0, 4'd2, 32'h0, 32'h2222);

        for (int i = 0; i < 20; i++) begin
            step("saturate", 0, 0, 1, 4'd8, 32'h8, 2'b10, 4'd8, 4'd1, 32'(i), 32'h0);
        end
        check("sat_limit", 64'(fwd_hit_count), 64'd15);
        step("sat_regfile", 0, 0, 1, 4'd8, 32'h88, 2'b00, 4'd8, 4'd8, 32'h1, 32'h2);

        for (int i = 0; i < 12; i++) begin
            logic [T-1:0] tg;
            tg = T'($urandom_range(0, 3));
            step("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom), tg, $urandom, 2'($urandom),
                 T'($urandom_range(0, 3)), T'($urandom_range(0, 3)), $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_forward_stage.md
Name: operand_forward_stage

Overview:
- Registered, parametrised operand-forwarding selector for one ALU operand in the ARM pipeline, sitting at the ID/EX boundary.
- Compares the operand's source register tag against NUM_SRC in-flight writer tags: EX/MEM, MEM/WB, and optional extra stages.
- Selects the youngest matching writer, or the register-file value if none match. Registers the result with stall (hold) and flush.
- Replaces the bare combinational forwarding mux and its undefined "hold last value" selection with a defined register.

Parameters:
- WORD_LENGTH, 32, operand/data width in bits.
- NUM_SRC, 2, number of forwarding sources; index 0 = youngest (MEM), higher = older (WB, ...); legal range 1..8.
- TAG_WIDTH, 4, register-tag width (ARM R0-R15).
- CNT_WIDTH, 16, width of the forward-hit statistics counter.

Ports:
- clk  input  1  pipeline clock, all state rises on posedge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  freeze: hold all registered outputs and the counter.
- flush  input  1  squash: next registered output is a bubble.
- in_valid  input  1  the ID-stage instruction uses this operand.
- src_tag  input  TAG_WIDTH  source register number of the operand.
- id_value  input  WORD_LENGTH  register-file read value.
- fwd_valid  input  NUM_SRC  per-source "writes back a register" flag.
- fwd_tag  input  NUM_SRC*TAG_WIDTH  destination tags, source i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- fwd_data  input  NUM_SRC*WORD_LENGTH  forwarded data, packed the same way.
- out_value  output  WORD_LENGTH  registered selected operand.
- out_valid  output  1  registered operand valid.
- out_sel  output  SEL_W  registered selection; 0 = register file, i+1 = source i. SEL_W = clog2(NUM_SRC+1).
- fwd_hit_count  output  CNT_WIDTH  saturating count of accepted forwarded operands.

Behaviour:
- Reset (async, rst=1): out_value=0, out_valid=0, out_sel=0, fwd_hit_count=0. Effective immediately, independent of clk. Stall and flush are ignored while rst is high.
- Match: match[i] = fwd_valid[i] && (fwd_tag[i] == src_tag). Combinational only.
- Priority: the lowest index i with match[i] wins. sel_next = i+1, value_next = fwd_data[i]. With no match: sel_next = 0, value_next = id_value.
- in_valid=0: sel_next=0 and value_next=id_value. Data is don't-care but deterministic.
- Register update at posedge clk, in strict priority order:
  1. flush=1 (wins even if stall=1): out_valid←0, out_sel←0, out_value←0. Counter unchanged.
  2. Else stall=1: all outputs and the counter hold their values.
  3. Else: out_valid←in_valid, out_sel←sel_next, out_value←value_next.
- Latency: exactly 1 cycle from inputs to registered outputs. No combinational path from inputs to outputs.
- Counter: increments by 1 on an accepted cycle (rule 3) when in_valid=1 and sel_next≠0. It saturates at all-ones and never wraps.
- Multiple matches: only the youngest is used; older matches are ignored. Duplicate tags across sources are legal.
- Tag width: tags compare full TAG_WIDTH, with no special handling of R15/PC. R15 forwarding is the hazard unit's responsibility.
- Reset deasserting mid-stall: the first active edge with stall=1 holds the reset values.

Decomposition:
- Shared package (arm_pipe_pkg):
  - TAG_WIDTH and WORD_LENGTH defaults.
  - Source-index constants FWD_SRC_MEM=0 and FWD_SRC_WB=1.
  - SEL encoding constant SEL_REGFILE=0.
- Sub-module fwd_priority_select:
  - Purely combinational.
  - Inputs: match vector and packed data. Outputs: sel_next and value_next.
  - Parametrised on NUM_SRC/WORD_LENGTH and reusable for operand B and the store-data path.
  - The top level owns the match compare, registers and counter.

Test Plan:
- Reset: assert rst mid-cycle with outputs nonzero → outputs and count go to 0 before the next edge. Release, with stall=0 and in_valid=0 → out_valid=0.
- No hazard: src_tag=3, id_value=0x11, fwd_valid=00 → next cycle out_value=0x11, out_sel=0, out_valid=1, count unchanged.
- Priority (NUM_SRC=2): src_tag=5, fwd_tag={5,5}, fwd_valid=11, data0=0xAAAA, data1=0xBBBB → out_value=0xAAAA, out_sel=1, count+1. Then fwd_valid=10 → out_value=0xBBBB, out_sel=2.
- Stall hold: after a forwarded result, raise stall=1 for 3 cycles while changing all inputs → outputs and count are frozen. Drop stall → the new value appears one cycle later.
- Flush beats stall: stall=1, flush=1 with a matching source → out_valid=0, out_value=0, out_sel=0, count unchanged.
- Saturation (CNT_WIDTH=4): 20 consecutive forwarded accepts → fwd_hit_count stops at 15. A non-forwarded accept leaves 15.
